data_mem_lsu: RTL
=================

# data_mem_lsu

Parametrised successor to the single-cycle word data memory: a byte-addressed, little-endian data RAM behind a valid/ready request port with configurable wait states. Supports RV32I load/store sizes (byte, half, word) with sign/zero extension selected by funct3, and flags illegal size codes. It sits in the MEM stage of the pipelined core; the hazard unit stalls the pipeline on `req_ready` low and resumes on `resp_valid`.

## Interface
- `WIDTH`, 32, data and address width.
- `DATA_WIDTH`, 8, storage element width (one byte).
- `SIZE`, 17, address bits actually decoded; RAM holds 2**SIZE bytes.
- `WAIT_CYCLES`, 2, wait states between acceptance and access (0..15).

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  access size/sign code (RV32I encoding).
- `adr`  in  WIDTH  byte address.
- `write_data`  in  WIDTH  store data, least-significant bytes used.
- `resp_valid`  out  1  one-cycle pulse: access completed.
- `resp_err`  out  1  qualifies `resp_valid`: illegal funct3.
- `read_data`  out  WIDTH  load result, valid with `resp_valid`.

## Operation
- FSM states IDLE, WAIT, RESP. `req_ready` = 1 in IDLE and RESP, 0 in WAIT.
- Handshake: request accepted on an edge where `req_valid && req_ready`; `req_write`, `req_funct3`, `adr`, `write_data` latched then. Inputs ignored at other times.
- On accept: WAIT_CYCLES > 0 -> WAIT, counter loaded with WAIT_CYCLES-1; WAIT_CYCLES = 0 -> access performed on the accepting edge, go to RESP.
- WAIT: counter decrements each cycle; on the edge where counter = 0 the access is performed, go to RESP.
- RESP: `resp_valid` = 1 for exactly one cycle. A new request accepted in RESP goes straight to WAIT (or stays in RESP if WAIT_CYCLES = 0); otherwise -> IDLE.
- Index = `adr[SIZE-1:0]`; byte k of an access at index+k modulo 2**SIZE (wraps at top of RAM, no fault). Misaligned accesses legal.
- funct3 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU. Stores with 100/101 and any access with 011/110/111 are illegal: no RAM write, `read_data` = 0, `resp_err` = 1.
- Loads: LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW returns 4 bytes little-endian.
- Stores write only 1/2/4 bytes; other bytes unchanged. Store response: `read_data` = 0, `resp_err` = 0.
- Read data is captured into a register at the access edge; a later store does not alter a pending response.

## Timing
- Reset: state IDLE, counter 0, `req_ready` = 1, `resp_valid` = 0, `resp_err` = 0, `read_data` = 0. RAM contents not reset.
- Latency: accept at edge T -> `resp_valid` high during cycle T+WAIT_CYCLES+1.
- Throughput: one request per WAIT_CYCLES+1 cycles with back-to-back acceptance in RESP.
- Reset mid-operation: pending request discarded; a store not yet performed never writes; no response produced.
- `resp_err`, `read_data` hold their values only during the `resp_valid` cycle; 0 otherwise.

## Structure
- Package `data_mem_pkg`: `mem_state_t` enum (IDLE, WAIT, RESP), funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), legality function.
- Sub-module `byte_ram`: 2**SIZE x DATA_WIDTH array, combinational 4-byte read at index with wrap, synchronous write with 4 byte-lane enables. Top level holds FSM, counter, lane-enable decode, extension logic.

## Test plan
- WAIT_CYCLES=2: SW 0xDEADBEEF @0x100 accepted at T, then LW @0x100 -> store ack at T+3, load `resp_valid` at its accept+3 with `read_data` = 0xDEADBEEF.
- After above: LB @0x100 -> 0xFFFFFFEF; LBU @0x100 -> 0x000000EF; LH @0x102 -> 0xFFFFDEAD; LHU @0x101 -> 0x0000ADBE.
- SB 0x12 @0x101 over 0xDEADBEEF, then LW @0x100 -> 0xDEAD12EF (other bytes untouched).
- SW 0xA1B2C3D4 @0x1FFFE (top of RAM), LW @0x1FFFE -> 0xA1B2C3D4; LBU @0x0 -> 0xB2 (wrap).
- funct3=011 load and funct3=100 store -> `resp_valid` with `resp_err` = 1, `read_data` = 0; subsequent LW shows memory unchanged.
- SW accepted, `rst` asserted one cycle later for one cycle -> no `resp_valid`, `req_ready` = 1 next cycle, LW of that address returns prior contents; WAIT_CYCLES=0 build: back-to-back requests every cycle, responses one cycle after each accept.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and funct3 decoding for the byte-addressed data memory LSU.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam int LANES = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned sizes exist only for loads; stores accept B/H/W.
    function automatic logic f3_legal(input logic is_write, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_write;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [LANES-1:0] lane_mask(input logic [2:0] f3);
        logic [LANES-1:0] m;
        m = '0;
        case (f3)
            F3_B:    m = 4'b0001;
            F3_H:    m = 4'b0011;
            F3_W:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/data_mem_lsu_byte_ram.sv
// Byte-wide RAM with four consecutive lanes; lane addresses wrap at the top of the array.
module byte_ram
    import data_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SIZE       = 17
) (
    input  logic                        clk,
    input  logic [SIZE-1:0]             idx,
    input  logic [LANES-1:0]            we,
    input  logic [LANES*DATA_WIDTH-1:0] wdata,
    output logic [LANES*DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**SIZE];
    logic [SIZE-1:0]       lane_idx [LANES];

    // Modulo-2**SIZE addition gives the wrap-around for free.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_idx[gi] = idx + SIZE'(gi);
            assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] = mem[lane_idx[gi]];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (we[k]) begin
                mem[lane_idx[k]] <= wdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/data_mem_lsu.sv
// MEM-stage load/store unit: valid/ready request port, fixed wait states, RV32I sizes.
module data_mem_lsu
    import data_mem_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DATA_WIDTH  = 8,
    parameter int SIZE        = 17,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] write_data,
    output logic             resp_valid,
    output logic             resp_err,
    output logic [WIDTH-1:0] read_data
);

    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam bit         DIRECT   = (WAIT_CYCLES == 0);
    localparam int         HALF     = 2 * DATA_WIDTH;

    mem_state_t       state_reg, state_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic             write_reg;
    logic [2:0]       f3_reg;
    logic [SIZE-1:0]  idx_reg;
    logic [WIDTH-1:0] wdata_reg;
    logic [WIDTH-1:0] rdata_reg;
    logic             err_reg;

    logic             accept;
    logic             access;
    logic             acc_write;
    logic [2:0]       acc_f3;
    logic [SIZE-1:0]  acc_idx;
    logic [WIDTH-1:0] acc_wdata;
    logic             acc_legal;
    logic [LANES-1:0] lane_en;
    logic [WIDTH-1:0] ram_word;
    logic [WIDTH-1:0] load_val;
    logic             unused_adr;

    assign unused_adr = ^adr[WIDTH-1:SIZE];

    assign req_ready = (state_reg != WAIT);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        access     = 1'b0;
        case (state_reg)
            IDLE, RESP: begin
                if (state_reg == RESP) begin
                    state_next = IDLE;
                end
                if (accept) begin
                    if (DIRECT) begin
                        state_next = RESP;
                        access     = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                    access     = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // With no wait states the access happens on the accepting edge, so operands bypass the latches.
    assign acc_write = DIRECT ? req_write         : write_reg;
    assign acc_f3    = DIRECT ? req_funct3        : f3_reg;
    assign acc_idx   = DIRECT ? adr[SIZE-1:0]     : idx_reg;
    assign acc_wdata = DIRECT ? write_data        : wdata_reg;

    assign acc_legal = f3_legal(acc_write, acc_f3);
    assign lane_en   = (access && acc_write && acc_legal) ? lane_mask(acc_f3) : '0;

    byte_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIZE       (SIZE)
    ) u_ram (
        .clk   (clk),
        .idx   (acc_idx),
        .we    (lane_en),
        .wdata (acc_wdata),
        .rdata (ram_word)
    );

    always_comb begin
        load_val = '0;
        case (acc_f3)
            F3_B:  load_val = {{(WIDTH-DATA_WIDTH){ram_word[DATA_WIDTH-1]}}, ram_word[DATA_WIDTH-1:0]};
            F3_H:  load_val = {{(WIDTH-HALF){ram_word[HALF-1]}}, ram_word[HALF-1:0]};
            F3_W:  load_val = ram_word;
            F3_BU: load_val = {{(WIDTH-DATA_WIDTH){1'b0}}, ram_word[DATA_WIDTH-1:0]};
            F3_HU: load_val = {{(WIDTH-HALF){1'b0}}, ram_word[HALF-1:0]};
            default: load_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            write_reg <= 1'b0;
            f3_reg    <= 3'b000;
            idx_reg   <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                write_reg <= req_write;
                f3_reg    <= req_funct3;
                idx_reg   <= adr[SIZE-1:0];
                wdata_reg <= write_data;
            end
            if (access) begin
                err_reg   <= !acc_legal;
                rdata_reg <= (acc_legal && !acc_write) ? load_val : '0;
            end
        end
    end

    assign resp_valid = (state_reg == RESP);
    assign resp_err   = resp_valid && err_reg;
    assign read_data  = resp_valid ? rdata_reg : '0;

endmodule
